// File: rtl/edge_replay.sv
// Rebuilds an 8-bit level waveform from a stream of gap-tagged edge masks.
// Entries queue in a small FIFO. One pending entry counts its gap down and is then XORed into dout.
module edge_replay #(
    parameter int DEPTH = 4,
    parameter int GAPW  = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    input  logic [7:0]      in_mask,
    input  logic [GAPW-1:0] in_gap,
    output logic            in_ready,
    input  logic            flush,
    output logic [7:0]      dout,
    output logic [7:0]      edge_out,
    output logic            busy,
    output logic            fifo_empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [7:0]      mask_mem_q [DEPTH];
    logic [GAPW-1:0] gap_mem_q  [DEPTH];

    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            pend_valid_q, pend_valid_d;
    logic [7:0]      pend_mask_q, pend_mask_d;
    logic [GAPW-1:0] pend_cnt_q, pend_cnt_d;
    logic [7:0]      dout_q, dout_d;
    logic [7:0]      edge_q, edge_d;

    logic full, empty, push, apply, refill, mem_we;

    always_comb begin
        full   = (count_q == FULL_CNT);
        empty  = (count_q == '0);
        push   = in_valid && !full;
        apply  = pend_valid_q && (pend_cnt_q == '0);
        refill = (!pend_valid_q || apply) && !empty;
        mem_we = push;

        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        pend_valid_d = pend_valid_q;
        pend_mask_d  = pend_mask_q;
        pend_cnt_d   = pend_cnt_q;
        dout_d       = dout_q;
        edge_d       = 8'h00;

        if (apply) begin
            dout_d = dout_q ^ pend_mask_q;
            edge_d = pend_mask_q;
        end else if (pend_valid_q) begin
            pend_cnt_d = pend_cnt_q - GAPW'(1);
        end

        // Refill on the apply edge itself so gap=0 entries stream one per cycle.
        if (refill) begin
            pend_mask_d  = mask_mem_q[rd_ptr_q];
            pend_cnt_d   = gap_mem_q[rd_ptr_q];
            pend_valid_d = 1'b1;
            rd_ptr_d     = rd_ptr_q + AW'(1);
        end else if (apply) begin
            pend_valid_d = 1'b0;
        end

        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        count_d = count_q + {{(CW-1){1'b0}}, push} - {{(CW-1){1'b0}}, refill};

        // Flush drops everything queued or pending, including an apply due now; dout holds.
        if (flush) begin
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            count_d      = '0;
            pend_valid_d = 1'b0;
            pend_cnt_d   = '0;
            dout_d       = dout_q;
            edge_d       = 8'h00;
            mem_we       = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            pend_valid_q <= 1'b0;
            pend_cnt_q   <= '0;
            dout_q       <= 8'h00;
            edge_q       <= 8'h00;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            pend_valid_q <= pend_valid_d;
            pend_cnt_q   <= pend_cnt_d;
            dout_q       <= dout_d;
            edge_q       <= edge_d;
        end
    end

    // Payload storage carries no reset; pend_valid and the occupancy count qualify it.
    always_ff @(posedge clk) begin
        pend_mask_q <= pend_mask_d;
        if (mem_we && !reset) begin
            mask_mem_q[wr_ptr_q] <= in_mask;
            gap_mem_q[wr_ptr_q]  <= in_gap;
        end
    end

    assign in_ready   = !full;
    assign busy       = pend_valid_q || !empty;
    assign fifo_empty = empty;
    assign dout       = dout_q;
    assign edge_out   = edge_q;

endmodule

// File: tb/tb_edge_replay.sv
// Directed and looped-back checks for edge_replay.
// Applied edges are matched against a queue of expected (mask, dout, cycle) entries.
module tb_edge_replay;

    logic       clk = 1'b0;
    logic       reset, in_valid, flush;
    logic [7:0] in_mask;
    logic [3:0] in_gap;
    logic       in_ready, busy, fifo_empty;
    logic [7:0] dout, edge_out;

    edge_replay #(.DEPTH(4), .GAPW(4)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_mask(in_mask),
        .in_gap(in_gap), .in_ready(in_ready), .flush(flush), .dout(dout),
        .edge_out(edge_out), .busy(busy), .fifo_empty(fifo_empty)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] mask;
        logic [7:0] dout;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   a_prev = -100;
    int   rst_cyc = -100;
    logic det_en = 1'b0;
    logic [7:0] det_prev, det_q, eo_d1;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference any-edge detector fed with dout.
    always @(posedge clk) begin
        det_prev <= dout;
        det_q    <= dout ^ det_prev;
        eo_d1    <= edge_out;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cyc %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (edge_out != 8'h00) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_edge: got %0h want none (cyc %0d)", edge_out, cyc);
            end else begin
                e = sb.pop_front();
                chk("edge_mask", 32'(edge_out), 32'(e.mask));
                chk("edge_dout", 32'(dout), 32'(e.dout));
                chk("edge_cyc", 32'(cyc), 32'(e.cyc));
            end
        end
        if (det_en && cyc > rst_cyc + 2)
            chk("detector", 32'(det_q), 32'(eo_d1));
    end

    // Called at a negedge; the entry is accepted on the first edge with in_ready high.
    task automatic push(input logic [7:0] m, input logic [3:0] g, input logic [7:0] exp_d,
                        output int waited, output int ap);
        int p, t;
        waited   = 0;
        in_valid = 1'b1;
        in_mask  = m;
        in_gap   = g;
        while (!in_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) chk("push_timeout", 32'(in_ready), 32'd1);
        p = cyc + 1;
        t = (p + 1 > a_prev) ? p + 1 : a_prev;
        ap = t + int'(g) + 1;
        a_prev = ap;
        if (m != 8'h00) sb.push_back('{m, exp_d, ap});
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (busy && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("drain_busy", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
    endtask

    int w, a, a0, n;
    logic [7:0] m, exp_dout;

    initial begin
        reset = 1'b1; in_valid = 1'b0; flush = 1'b0; in_mask = 8'h00; in_gap = 4'h0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        chk("rst_dout", 32'(dout), 32'h00);
        chk("rst_edge", 32'(edge_out), 32'h00);
        chk("rst_ready", 32'(in_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_empty", 32'(fifo_empty), 32'd1);

        push(8'h01, 4'd0, 8'h01, w, a);
        drain();
        push(8'h01, 4'd3, 8'h00, w, a);
        drain();
        chk("t2_dout", 32'(dout), 32'h00);

        push(8'h06, 4'd0, 8'h06, w, a); chk("t3_ready0", 32'(w), 32'd0);
        push(8'h06, 4'd0, 8'h00, w, a); chk("t3_ready1", 32'(w), 32'd0);
        push(8'hFF, 4'd0, 8'hFF, w, a); chk("t3_ready2", 32'(w), 32'd0);
        push(8'h80, 4'd0, 8'h7F, w, a); chk("t3_ready3", 32'(w), 32'd0);
        drain();
        push(8'h00, 4'd2, 8'h7F, w, a);
        push(8'h03, 4'd0, 8'h7C, w, a);
        push(8'h10, 4'd15, 8'h6C, w, a);
        drain();
        chk("t3_dout", 32'(dout), 32'h6C);

        push(8'h01, 4'd15, 8'h6D, w, a0);
        push(8'h02, 4'd0, 8'h6F, w, a);
        push(8'h04, 4'd0, 8'h6B, w, a);
        push(8'h08, 4'd0, 8'h63, w, a);
        push(8'h10, 4'd0, 8'h73, w, a);
        chk("full_ready", 32'(in_ready), 32'd0);
        chk("full_empty", 32'(fifo_empty), 32'd0);
        in_valid = 1'b1; in_mask = 8'h40; in_gap = 4'd0;
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        in_valid = 1'b0;
        chk("ready_rise_cyc", 32'(cyc), 32'(a0));
        push(8'h40, 4'd0, 8'h33, w, a);
        drain();
        chk("t4_dout", 32'(dout), 32'h33);

        push(8'h69, 4'd0, 8'h5A, w, a);
        drain();
        push(8'h01, 4'd15, 8'h5B, w, a);
        push(8'h02, 4'd0, 8'h59, w, a);
        push(8'h04, 4'd0, 8'h5D, w, a);
        push(8'h08, 4'd0, 8'h55, w, a);
        chk("pre_flush_busy", 32'(busy), 32'd1);
        flush = 1'b1; in_valid = 1'b1; in_mask = 8'h80; in_gap = 4'd0;
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        sb.delete();
        a_prev = -100;
        chk("flush_dout", 32'(dout), 32'h5A);
        chk("flush_busy", 32'(busy), 32'd0);
        chk("flush_empty", 32'(fifo_empty), 32'd1);
        chk("flush_edge", 32'(edge_out), 32'h00);
        repeat (20) @(negedge clk);
        chk("flush_hold", 32'(dout), 32'h5A);

        exp_dout = dout;
        det_en = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (i == 100) begin
                in_valid = 1'b0;
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
                rst_cyc = cyc;
                sb.delete();
                a_prev = -100;
                exp_dout = 8'h00;
                chk("mid_rst_dout", 32'(dout), 32'h00);
                chk("mid_rst_ready", 32'(in_ready), 32'd1);
                chk("mid_rst_busy", 32'(busy), 32'd0);
            end
            m = 8'($urandom_range(0, 255));
            exp_dout = exp_dout ^ m;
            push(m, 4'($urandom_range(0, 2)), exp_dout, w, a);
        end
        drain();
        chk("final_dout", 32'(dout), 32'(exp_dout));
        chk("sb_left", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
